// File: rtl/router_mon_pkg.sv
// Shared types and destination-field layout for the router terminal monitor.
// The destination field sits in the low bits of every packet.
package router_mon_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_STALL = 2'd2
   } term_state_e;

   localparam int DST_W   = 6;
   localparam int DST_LSB = 0;
   localparam int DST_MSB = DST_LSB + DST_W - 1;

   localparam logic [DST_W-1:0] BCAST_ID = {DST_W{1'b1}};

endpackage

// File: rtl/router_term_fsm.sv
// Per-terminal packet tracker: wait counter, sticky error flags, worst-case latency.
module router_term_fsm
   import router_mon_pkg::*;
#(
   parameter int TERM_ID  = 0,
   parameter int PCK_SZ   = 40,
   parameter int TIMEOUT  = 128,
   parameter int CNT_W    = 8,
   parameter bit BCAST_EN = 1'b0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              mon_en,
   input  logic              clr,
   input  logic [PCK_SZ-1:0] pkt,
   input  logic              pndng,
   input  logic              pop,
   output logic              err_timeout,
   output logic              err_dst,
   output logic              err_spur,
   output logic [CNT_W-1:0]  max_wait,
   output logic              err_evt
);

   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] TMO_C    = CNT_W'(TIMEOUT);
   localparam logic [DST_W-1:0] ID_C     = DST_W'(TERM_ID);

   term_state_e      state_r, state_s;
   logic [CNT_W-1:0] cnt_r, cnt_s;
   logic [CNT_W-1:0] lat_s, mw_base_s, mw_next_s;
   logic [DST_W-1:0] dst_s;
   logic             dst_ok_s, lat_vld_s;
   logic             tmo_evt_s, dst_evt_s, spur_evt_s;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      if (v == CNT_MAX) begin
         return CNT_MAX;
      end else begin
         return v + CNT_ONE;
      end
   endfunction

   assign dst_s    = pkt[DST_MSB:DST_LSB];
   assign dst_ok_s = (dst_s == ID_C) || (BCAST_EN && (dst_s == BCAST_ID));
   assign err_evt  = mon_en & (tmo_evt_s | dst_evt_s | spur_evt_s);

   // Next state, wait counter and this cycle's error events.
   always_comb begin
      state_s    = state_r;
      cnt_s      = cnt_r;
      lat_s      = cnt_r;
      lat_vld_s  = 1'b0;
      tmo_evt_s  = 1'b0;
      dst_evt_s  = 1'b0;
      spur_evt_s = pop & ~pndng;
      case (state_r)
         ST_IDLE: begin
            if (pndng) begin
               dst_evt_s = ~dst_ok_s;
               if (pop) begin
                  lat_vld_s = 1'b1;
                  lat_s     = CNT_ZERO;
               end else begin
                  state_s = ST_WAIT;
                  cnt_s   = CNT_ONE;
               end
            end else begin
               cnt_s = CNT_ZERO;
            end
         end
         ST_WAIT, ST_STALL: begin
            // A pop with nothing pending is only flagged; the tracked packet is kept.
            if (!pndng) begin
               if (!pop) begin
                  state_s = ST_IDLE;
                  cnt_s   = CNT_ZERO;
               end else begin
                  state_s = state_r;
               end
            end else if (pop) begin
               lat_vld_s = 1'b1;
               state_s   = ST_IDLE;
               cnt_s     = CNT_ZERO;
            end else if ((state_r == ST_WAIT) && (cnt_r == TMO_C)) begin
               state_s   = ST_STALL;
               tmo_evt_s = 1'b1;
               cnt_s     = sat_inc(cnt_r);
            end else begin
               cnt_s = sat_inc(cnt_r);
            end
         end
         default: begin
            state_s = ST_IDLE;
            cnt_s   = CNT_ZERO;
         end
      endcase
   end

   // Worst-case latency, rebased on zero when cleared in the same cycle.
   always_comb begin
      if (clr) begin
         mw_base_s = CNT_ZERO;
      end else begin
         mw_base_s = max_wait;
      end
      if (lat_vld_s && (lat_s > mw_base_s)) begin
         mw_next_s = lat_s;
      end else begin
         mw_next_s = mw_base_s;
      end
   end

   // State, counter and sticky output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= ST_IDLE;
         cnt_r       <= CNT_ZERO;
         err_timeout <= 1'b0;
         err_dst     <= 1'b0;
         err_spur    <= 1'b0;
         max_wait    <= CNT_ZERO;
      end else if (mon_en) begin
         state_r     <= state_s;
         cnt_r       <= cnt_s;
         err_timeout <= (err_timeout & ~clr) | tmo_evt_s;
         err_dst     <= (err_dst & ~clr) | dst_evt_s;
         err_spur    <= (err_spur & ~clr) | spur_evt_s;
         max_wait    <= mw_next_s;
      end
   end

endmodule

// File: rtl/router_term_monitor.sv
// Mesh edge-terminal monitor: one tracker per terminal plus a global saturating error count.
module router_term_monitor
   import router_mon_pkg::*;
#(
   parameter int ROWS     = 4,
   parameter int COLUMS   = 4,
   parameter int PCK_SZ   = 40,
   parameter int TIMEOUT  = 128,
   parameter int CNT_W    = 8,
   parameter int BCAST_EN = 0,
   localparam int N_TERMS = 2 * ROWS + 2 * COLUMS
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [PCK_SZ-1:0]  data_out [N_TERMS],
   input  logic [N_TERMS-1:0] pndng,
   input  logic [N_TERMS-1:0] pop,
   input  logic               mon_en,
   input  logic               clr,
   output logic [N_TERMS-1:0] err_timeout,
   output logic [N_TERMS-1:0] err_dst,
   output logic [N_TERMS-1:0] err_spur,
   output logic [CNT_W-1:0]   max_wait [N_TERMS],
   output logic [CNT_W-1:0]   err_total
);

   localparam int SUM_W = CNT_W + $clog2(N_TERMS + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [N_TERMS-1:0] err_evt_s;
   logic [SUM_W-1:0]   evt_cnt_s, sum_s;
   logic [CNT_W-1:0]   total_next_s;

   for (genvar g = 0; g < N_TERMS; g++) begin : g_term
      router_term_fsm #(
         .TERM_ID  (g),
         .PCK_SZ   (PCK_SZ),
         .TIMEOUT  (TIMEOUT),
         .CNT_W    (CNT_W),
         .BCAST_EN (BCAST_EN != 0)
      ) u_term (
         .clk         (clk),
         .reset       (reset),
         .mon_en      (mon_en),
         .clr         (clr),
         .pkt         (data_out[g]),
         .pndng       (pndng[g]),
         .pop         (pop[g]),
         .err_timeout (err_timeout[g]),
         .err_dst     (err_dst[g]),
         .err_spur    (err_spur[g]),
         .max_wait    (max_wait[g]),
         .err_evt     (err_evt_s[g])
      );
   end

   // Popcount of this cycle's events added to the (possibly cleared) total, saturating.
   always_comb begin
      evt_cnt_s = {SUM_W{1'b0}};
      for (int i = 0; i < N_TERMS; i++) begin
         evt_cnt_s = evt_cnt_s + SUM_W'(err_evt_s[i]);
      end
      if (clr) begin
         sum_s = evt_cnt_s;
      end else begin
         sum_s = SUM_W'(err_total) + evt_cnt_s;
      end
      if (sum_s > SUM_W'(CNT_MAX)) begin
         total_next_s = CNT_MAX;
      end else begin
         total_next_s = sum_s[CNT_W-1:0];
      end
   end

   // Global error total register.
   always_ff @(posedge clk) begin
      if (reset) begin
         err_total <= {CNT_W{1'b0}};
      end else if (mon_en) begin
         err_total <= total_next_s;
      end
   end

endmodule

// File: tb/tb_router_term_monitor.sv
// Randomized and directed bench for router_term_monitor, with and without broadcast.
module tb_router_term_monitor;
   import router_mon_pkg::*;

   localparam int N   = 16;
   localparam int CW  = 8;
   localparam int TMO = 128;
   localparam int PS  = 40;
   localparam int SAT = 255;

   logic          clk = 1'b0;
   logic          reset, mon_en, clr;
   logic [PS-1:0] data_out [N];
   logic [N-1:0]  pndng, pop;
   logic [N-1:0]  tmo0, tmo1, dst0, dst1, spur0, spur1;
   logic [CW-1:0] mw0 [N];
   logic [CW-1:0] mw1 [N];
   logic [CW-1:0] tot0, tot1;

   int n_cmp = 0;
   int n_err = 0;

   // Reference state: packet age in cycles, whether the head was already seen.
   int age    [2][N];
   bit in_pkt [2][N];
   bit m_tmo  [2][N];
   bit m_dst  [2][N];
   bit m_spur [2][N];
   int m_mw   [2][N];
   int m_tot  [2];
   int pop_rate [N];

   always #5 clk = ~clk;

   router_term_monitor #(.BCAST_EN(0)) dut0 (
      .clk(clk), .reset(reset), .data_out(data_out), .pndng(pndng), .pop(pop),
      .mon_en(mon_en), .clr(clr), .err_timeout(tmo0), .err_dst(dst0),
      .err_spur(spur0), .max_wait(mw0), .err_total(tot0));

   router_term_monitor #(.BCAST_EN(1)) dut1 (
      .clk(clk), .reset(reset), .data_out(data_out), .pndng(pndng), .pop(pop),
      .mon_en(mon_en), .clr(clr), .err_timeout(tmo1), .err_dst(dst1),
      .err_spur(spur1), .max_wait(mw1), .err_total(tot1));

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic set_dst(input int i, input int d);
      logic [63:0] t;
      t = {$urandom(), $urandom()};
      data_out[i] = t[PS-1:0];
      data_out[i][DST_MSB:DST_LSB] = d[DST_W-1:0];
   endtask

   task automatic model_step();
      int evts, d, lat;
      for (int k = 0; k < 2; k++) begin
         if (reset) begin
            for (int i = 0; i < N; i++) begin
               age[k][i] = 0; in_pkt[k][i] = 1'b0;
               m_tmo[k][i] = 1'b0; m_dst[k][i] = 1'b0; m_spur[k][i] = 1'b0; m_mw[k][i] = 0;
            end
            m_tot[k] = 0;
         end else if (mon_en) begin
            evts = 0;
            if (clr) begin
               for (int i = 0; i < N; i++) begin
                  m_tmo[k][i] = 1'b0; m_dst[k][i] = 1'b0; m_spur[k][i] = 1'b0; m_mw[k][i] = 0;
               end
               m_tot[k] = 0;
            end
            for (int i = 0; i < N; i++) begin
               d = int'(data_out[i][DST_MSB:DST_LSB]);
               if (pop[i] && !pndng[i]) begin
                  m_spur[k][i] = 1'b1; evts++;
               end else if (pndng[i]) begin
                  if (!in_pkt[k][i]) begin
                     age[k][i] = 0;
                     if (d != i && !(k == 1 && d == 63)) begin
                        m_dst[k][i] = 1'b1; evts++;
                     end
                  end
                  if (pop[i]) begin
                     lat = (age[k][i] > SAT) ? SAT : age[k][i];
                     if (lat > m_mw[k][i]) m_mw[k][i] = lat;
                     in_pkt[k][i] = 1'b0;
                  end else begin
                     if (in_pkt[k][i] && age[k][i] == TMO) begin
                        m_tmo[k][i] = 1'b1; evts++;
                     end
                     in_pkt[k][i] = 1'b1;
                     age[k][i]++;
                  end
               end else begin
                  in_pkt[k][i] = 1'b0;
               end
            end
            m_tot[k] = (m_tot[k] + evts > SAT) ? SAT : m_tot[k] + evts;
         end
      end
   endtask

   task automatic compare_all();
      logic [N-1:0] et, ed, es;
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < N; i++) begin
            et[i] = m_tmo[k][i]; ed[i] = m_dst[k][i]; es[i] = m_spur[k][i];
            check_val($sformatf("b%0d_max_wait%0d", k, i),
                      32'(k == 0 ? mw0[i] : mw1[i]), 32'(m_mw[k][i]));
         end
         check_val($sformatf("b%0d_err_timeout", k), 32'(k == 0 ? tmo0 : tmo1), 32'(et));
         check_val($sformatf("b%0d_err_dst", k), 32'(k == 0 ? dst0 : dst1), 32'(ed));
         check_val($sformatf("b%0d_err_spur", k), 32'(k == 0 ? spur0 : spur1), 32'(es));
         check_val($sformatf("b%0d_err_total", k), 32'(k == 0 ? tot0 : tot1), 32'(m_tot[k]));
      end
   endtask

   task automatic step();
      model_step();
      @(posedge clk);
      #1;
      compare_all();
   endtask

   task automatic quiet();
      pndng = '0; pop = '0; clr = 1'b0; mon_en = 1'b1; reset = 1'b0;
   endtask

   initial begin
      quiet();
      reset = 1'b1;
      for (int i = 0; i < N; i++) begin
         set_dst(i, i);
         pop_rate[i] = (i < 4) ? 3 : 150;
      end
      step();
      step();
      check_val("reset_total", 32'(tot0), 32'd0);
      reset = 1'b0;

      // Five-cycle wait on terminal 3.
      set_dst(3, 3); pndng[3] = 1'b1;
      repeat (5) step();
      pop[3] = 1'b1;
      step();
      quiet();
      step();
      check_val("lat5_max_wait3", 32'(mw0[3]), 32'd5);
      check_val("lat5_no_error", 32'(tot0), 32'd0);

      // Timeout on terminal 7, then a late pop.
      set_dst(7, 7); pndng[7] = 1'b1;
      repeat (128) step();
      check_val("tmo_not_yet", 32'(tmo0[7]), 32'd0);
      step();
      check_val("tmo_flag7", 32'(tmo0[7]), 32'd1);
      check_val("tmo_total", 32'(tot0), 32'd1);
      repeat (71) step();
      pop[7] = 1'b1;
      step();
      check_val("late_max_wait7", 32'(mw0[7]), 32'd200);
      quiet();
      step();

      // Broadcast destination on terminal 2.
      set_dst(2, 63); pndng[2] = 1'b1; pop[2] = 1'b1;
      step();
      check_val("bcast_off_dst2", 32'(dst0[2]), 32'd1);
      check_val("bcast_on_dst2", 32'(dst1[2]), 32'd0);
      quiet();
      clr = 1'b1;
      step();
      clr = 1'b0;

      // Three simultaneous events, then saturation from 254.
      set_dst(4, 0); set_dst(9, 0);
      pndng[4] = 1'b1; pndng[9] = 1'b1; pop[1] = 1'b1;
      step();
      check_val("three_events", 32'(tot0), 32'd3);
      quiet();
      step();
      clr = 1'b1;
      step();
      clr = 1'b0;
      pop = '1;
      repeat (15) step();
      pop = 16'h3FFF;
      step();
      check_val("total_254", 32'(tot0), 32'd254);
      pop = 16'h0002; pndng[4] = 1'b1; pndng[9] = 1'b1;
      step();
      check_val("total_sat", 32'(tot0), 32'd255);
      quiet();
      step();

      // Reset in the middle of a wait on terminal 5.
      set_dst(5, 5); pndng[5] = 1'b1;
      repeat (50) step();
      reset = 1'b1;
      step();
      check_val("rst_total", 32'(tot0), 32'd0);
      check_val("rst_spur", 32'(spur0), 32'd0);
      check_val("rst_dst", 32'(dst0), 32'd0);
      check_val("rst_max_wait7", 32'(mw0[7]), 32'd0);
      quiet();
      repeat (150) step();
      check_val("rst_no_tmo5", 32'(tmo0[5]), 32'd0);

      // Clear coinciding with a spurious pop.
      pop[0] = 1'b1; step();
      pop[0] = 1'b0; pop[2] = 1'b1; step();
      pop[2] = 1'b0; pop[0] = 1'b1; clr = 1'b1; step();
      check_val("clr_spur_total", 32'(tot0), 32'd1);
      check_val("clr_spur0", 32'(spur0[0]), 32'd1);
      check_val("clr_spur2", 32'(spur0[2]), 32'd0);
      quiet();
      step();

      // Random traffic.
      for (int c = 0; c < 1500; c++) begin
         for (int i = 0; i < N; i++) begin
            if (pndng[i] && !pop[i]) begin
               if ($urandom_range(99) < 2) pndng[i] = 1'b0;
            end else if (pndng[i]) begin
               pndng[i] = ($urandom_range(99) < 50);
            end else begin
               pndng[i] = ($urandom_range(99) < 20);
            end
            if (pndng[i] && $urandom_range(99) < 30) begin
               case ($urandom_range(9))
                  0, 1:    set_dst(i, 63);
                  2, 3:    set_dst(i, int'($urandom_range(63)));
                  default: set_dst(i, i);
               endcase
            end
            pop[i] = pndng[i] ? ($urandom_range(999) < pop_rate[i]) : ($urandom_range(99) < 3);
         end
         mon_en = ($urandom_range(99) >= 5);
         clr    = ($urandom_range(99) < 2);
         reset  = ($urandom_range(999) < 3);
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
